sysbus_arbiter: RTL and testbench

Two-requester Sysbus arbiter and line-read sequencer. It sits between the core's instruction-fetch path (requester 0) and data-memory path (requester 1) and the single shared Sysbus port. It serialises their cache-line read requests onto the bus and collects the 8-beat response into one 512-bit line. It returns that line to whichever requester owns the transaction.

---
 rtl/sysbus_arbiter.sv | 169 ++++++++++++++++
 tb/tb_sysbus_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: two-requester Sysbus arbiter and cache-line read sequencer.
// Requester 0 is instruction fetch and requester 1 is data memory. Only one line
// read is outstanding at a time. Each line is collected from BEATS response beats
// and returned to the requester that owns the transaction.
// Optional feature: define BUSARB_RR_EN for round-robin arbitration. When it is
// left undefined, requester 0 has fixed priority.

`ifndef SYSBUS_READ
`define SYSBUS_READ 1'b1
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'b0001
`endif

module sysbus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [1:0]                      req_valid,
    input  logic [BUS_DATA_WIDTH-1:0]       req_addr_0,
    input  logic [BUS_DATA_WIDTH-1:0]       req_addr_1,
    output logic [1:0]                      req_grant,
    output logic [1:0]                      rsp_valid,
    output logic [BUS_DATA_WIDTH*BEATS-1:0] rsp_data,
    output logic                            bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0]       bus_req,
    output logic [BUS_TAG_WIDTH-1:0]        bus_reqtag,
    input  logic                            bus_reqack,
    input  logic                            bus_respcyc,
    output logic                            bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0]       bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]        bus_resptag
);

    // Byte offset bits inside one line. These are cleared in the bus address.
    localparam int OFFSET_BITS = $clog2(BEATS * BUS_DATA_WIDTH / 8);
    localparam int CNT_W       = $clog2(BEATS);
    localparam logic [BUS_DATA_WIDTH-1:0] LINE_MASK = {BUS_DATA_WIDTH{1'b1}} << OFFSET_BITS;
    localparam logic [CNT_W-1:0]          LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        RESP,
        DONE
    } state_t;

    state_t                    state;
    logic [CNT_W-1:0]          count;
    logic                      owner;
    logic                      win_id;
    logic [BUS_DATA_WIDTH-1:0] win_addr;
    logic                      beat_accept;
    logic [BUS_DATA_WIDTH-1:0] line_buf [BEATS];
    logic [BUS_DATA_WIDTH*BEATS-1:0] line_next;

`ifdef BUSARB_RR_EN
    // The pointer names the requester that is favoured when both are requesting.
    logic rr_ptr;
`endif

    // With a single transaction outstanding, the response tag carries no information.
    logic unused_resptag;
    assign unused_resptag = ^bus_resptag;

    // Beats count only while a response is expected. Stray beats at other times are not acknowledged.
    assign beat_accept = bus_respcyc && ((state == WAIT) || (state == RESP));
    assign bus_respack = beat_accept;

    // Select the winner from the current requests. The choice is used only in IDLE.
    always_comb begin
        win_id = 1'b0;
`ifdef BUSARB_RR_EN
        if (req_valid == 2'b11) begin
            win_id = rr_ptr;
        end else begin
            win_id = ~req_valid[0];
        end
`else
        win_id = ~req_valid[0];
`endif
        win_addr = win_id ? req_addr_1 : req_addr_0;
    end

    // Build the completed line: the stored beats plus the beat arriving in the final slot.
    always_comb begin
        line_next = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (k == BEATS - 1) begin
                line_next[k*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = bus_resp;
            end else begin
                line_next[k*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = line_buf[k];
            end
        end
    end

    // Beat storage. After a reset, slots are always rewritten before they are read.
    always_ff @(posedge clk) begin
        if (beat_accept) begin
            line_buf[count] <= bus_resp;
        end
    end

    // Transaction sequencer. All bus and requester outputs are registered here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= '0;
            owner      <= 1'b0;
            bus_reqcyc <= 1'b0;
            bus_req    <= '0;
            bus_reqtag <= '0;
            req_grant  <= 2'b00;
            rsp_valid  <= 2'b00;
            rsp_data   <= '0;
`ifdef BUSARB_RR_EN
            rr_ptr     <= 1'b0;
`endif
        end else begin
            req_grant <= 2'b00;
            rsp_valid <= 2'b00;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        state      <= REQ;
                        owner      <= win_id;
                        count      <= '0;
                        bus_reqcyc <= 1'b1;
                        bus_req    <= win_addr & LINE_MASK;
                        bus_reqtag <= BUS_TAG_WIDTH'({`SYSBUS_READ, `SYSBUS_MEMORY, 7'b0, win_id});
                        req_grant  <= win_id ? 2'b10 : 2'b01;
                    end
                end
                REQ: begin
                    if (bus_reqack) begin
                        bus_reqcyc <= 1'b0;
                        state      <= WAIT;
                    end
                end
                WAIT, RESP: begin
                    if (bus_respcyc) begin
                        count <= count + 1'b1;
                        if (count == LAST_BEAT) begin
                            state     <= DONE;
                            rsp_valid <= owner ? 2'b10 : 2'b01;
                            rsp_data  <= line_next;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
`ifdef BUSARB_RR_EN
                    rr_ptr <= ~owner;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Bench for sysbus_arbiter: table of line reads, bus stall case, reset mid-response,
// stray response beats. Completed lines are checked by a scoreboard queue.
module tb_sysbus_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req_valid;
    logic [63:0]  req_addr_0, req_addr_1;
    logic [1:0]   req_grant, rsp_valid;
    logic [511:0] rsp_data;
    logic         bus_reqcyc;
    logic [63:0]  bus_req;
    logic [12:0]  bus_reqtag;
    logic         bus_reqack, bus_respcyc, bus_respack;
    logic [63:0]  bus_resp;
    logic [12:0]  bus_resptag;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       id;
        logic [511:0] line;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    typedef struct {
        logic [1:0]  mask;
        logic [63:0] a0;
        logic [63:0] a1;
        logic        id_fixed;
        logic        id_rr;
        logic [63:0] ea0;
        logic [63:0] ea1;
    } vec_t;
    vec_t tbl[8];

    sysbus_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_addr_0  (req_addr_0),
        .req_addr_1  (req_addr_1),
        .req_grant   (req_grant),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_respack (bus_respack),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every rsp_valid pulse must match the oldest pending line.
    always @(negedge clk) begin
        if (reset === 1'b1 && rsp_valid != 2'b00) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=%0b expected none", rsp_valid);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_rsp_valid", rsp_valid, mon_e.id ? 2'b10 : 2'b01);
                chk("sb_rsp_data", rsp_data, mon_e.line);
            end
        end
    end

    // One full line read. It is called at a negedge and returns at the negedge of the DONE cycle.
    task automatic do_txn(input logic [1:0] mask, input logic [63:0] a0, input logic [63:0] a1,
                          input logic id, input logic [63:0] eaddr, input logic [63:0] seed,
                          input int ack_delay, input int gap, input int exp_lat);
        int lat;
        int cyc;
        exp_t e;
        logic [63:0] beat;
        req_valid  = mask;
        req_addr_0 = a0;
        req_addr_1 = a1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (req_grant == 2'b00 && lat < 20);
        chk("grant_latency", lat, exp_lat);
        chk("grant", req_grant, id ? 2'b10 : 2'b01);
        chk("reqcyc", bus_reqcyc, 1'b1);
        chk("bus_req", bus_req, eaddr);
        chk("bus_reqtag", bus_reqtag, 13'h1100 | 13'(id));
        cyc = 0;
        for (int d = 0; d < ack_delay; d++) begin
            bus_reqack = 1'b0;
            @(negedge clk);
            cyc++;
            chk("reqcyc_held", bus_reqcyc, 1'b1);
            chk("grant_pulse", req_grant, 2'b00);
        end
        bus_reqack = 1'b1;
        @(negedge clk);
        cyc++;
        bus_reqack = 1'b0;
        chk("reqcyc_drop", bus_reqcyc, 1'b0);
        chk("grant_once", req_grant, 2'b00);
        e.id = id;
        e.line = '0;
        for (int k = 0; k < 8; k++) begin
            e.line[k*64 +: 64] = seed | (64'(k + 1) * 64'h11);
        end
        sb.push_back(e);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                for (int g = 0; g < gap; g++) begin
                    bus_respcyc = 1'b0;
                    #1;
                    chk("respack_gap", bus_respack, 1'b0);
                    @(negedge clk);
                    cyc++;
                end
            end
            beat = seed | (64'(k + 1) * 64'h11);
            bus_respcyc = 1'b1;
            bus_resp    = beat;
            #1;
            chk("respack_beat", bus_respack, 1'b1);
            chk("no_early_rsp", rsp_valid, 2'b00);
            @(negedge clk);
            cyc++;
        end
        bus_respcyc = 1'b0;
        chk("rsp_valid", rsp_valid, id ? 2'b10 : 2'b01);
        chk("rsp_latency", cyc, 9 + ack_delay + 7 * gap);
    endtask

    initial begin
        int lat;
        logic eid;
        logic [63:0] eaddr;

        tbl[0] = '{2'b01, 64'h0000_0000_1234_5678, 64'h0, 1'b0, 1'b0, 64'h0000_0000_1234_5640, 64'h0};
        tbl[1] = '{2'b10, 64'h0, 64'hDEAD_BEEF_0000_107F, 1'b1, 1'b1, 64'h0, 64'hDEAD_BEEF_0000_1040};
        tbl[2] = '{2'b11, 64'h2000, 64'h3008, 1'b0, 1'b0, 64'h2000, 64'h3000};
        tbl[3] = '{2'b11, 64'h2000, 64'h3008, 1'b0, 1'b1, 64'h2000, 64'h3000};
        tbl[4] = '{2'b11, 64'h2000, 64'h3008, 1'b0, 1'b0, 64'h2000, 64'h3000};
        tbl[5] = '{2'b11, 64'h2000, 64'h3008, 1'b0, 1'b1, 64'h2000, 64'h3000};
        tbl[6] = '{2'b10, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FFC0};
        tbl[7] = '{2'b01, 64'h0000_0000_0000_0040, 64'h0, 1'b0, 1'b0, 64'h40, 64'h0};

        reset = 1'b0;
        req_valid = 2'b00;
        req_addr_0 = '0;
        req_addr_1 = '0;
        bus_reqack = 1'b0;
        bus_respcyc = 1'b1;
        bus_resp = 64'hFFFF;
        bus_resptag = '0;
        repeat (3) @(negedge clk);
        chk("rst_grant", req_grant, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_reqcyc", bus_reqcyc, 1'b0);
        chk("rst_bus_req", bus_req, 64'h0);
        chk("rst_reqtag", bus_reqtag, 13'h0);
        chk("rst_respack", bus_respack, 1'b0);
        chk("rst_rsp_data", rsp_data, 512'h0);
        bus_respcyc = 1'b0;
        reset = 1'b1;

        // Stray beats in IDLE are neither acknowledged nor counted.
        bus_respcyc = 1'b1;
        bus_resp = 64'hDEAD_DEAD;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stray_respack", bus_respack, 1'b0);
            @(negedge clk);
        end
        bus_respcyc = 1'b0;

        for (int i = 0; i < 8; i++) begin
`ifdef BUSARB_RR_EN
            eid = tbl[i].id_rr;
`else
            eid = tbl[i].id_fixed;
`endif
            eaddr = eid ? tbl[i].ea1 : tbl[i].ea0;
            do_txn(tbl[i].mask, tbl[i].a0, tbl[i].a1, eid, eaddr, 64'(i) << 56, 0, 0, (i == 0) ? 1 : 2);
            if (i == 0) begin
                chk("line0_beat0", rsp_data[63:0], 64'h11);
                chk("line0_beat7", rsp_data[511:448], 64'h88);
            end
        end
        req_valid = 2'b00;
        @(negedge clk);

        // Bus stalls: delayed acceptance, gaps between beats.
        do_txn(2'b01, 64'h0000_0000_0000_1FFF, 64'h0, 1'b0, 64'h1FC0, 64'hC000_0000_0000_0000, 5, 2, 1);
        req_valid = 2'b00;
        @(negedge clk);
        chk("rsp_pulse_one", rsp_valid, 2'b00);

        // Reset after beat 3 discards the partial line.
        req_valid = 2'b10;
        req_addr_1 = 64'h5555_0000;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (req_grant == 2'b00 && lat < 20);
        chk("abort_grant", req_grant, 2'b10);
        bus_reqack = 1'b1;
        @(negedge clk);
        bus_reqack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus_respcyc = 1'b1;
            bus_resp = 64'hBAD0 + 64'(k);
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        chk("abort_grant0", req_grant, 2'b00);
        chk("abort_rsp_valid", rsp_valid, 2'b00);
        chk("abort_reqcyc", bus_reqcyc, 1'b0);
        chk("abort_bus_req", bus_req, 64'h0);
        chk("abort_reqtag", bus_reqtag, 13'h0);
        chk("abort_respack", bus_respack, 1'b0);
        chk("abort_rsp_data", rsp_data, 512'h0);
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        bus_respcyc = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", rsp_valid, 2'b00);
        end

        // A fresh transaction after the abort collects a full new line.
        do_txn(2'b01, 64'h0000_0000_8000_0010, 64'h0, 1'b0, 64'h8000_0000, 64'h7700_0000_0000_0000, 0, 0, 1);
        req_valid = 2'b00;
        repeat (4) begin
            @(negedge clk);
            chk("idle_no_rsp", rsp_valid, 2'b00);
        end
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
